inst_loader: RTL

Byte-stream program loader: the write-side counterpart of the single-cycle MIPS instruction ROM. It takes a length-prefixed byte stream (from a UART receiver or testbench) over a valid/ready handshake and packs each group of four bytes into one 32-bit word. Each word is written to the instruction memory in the same byte order the ROM read port un-flips. The processor is held in reset until a load completes successfully.

---
 rtl/inst_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Byte-stream program loader: packs a length-prefixed byte stream into
// 32-bit instruction memory writes and holds the CPU in reset until done.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 begin a load session (IDLE, DONE, ERROR only)
//   byte_valid/byte_data  incoming stream byte
//   byte_ready            loader accepts a byte this cycle
//   mem_we/addr/data      registered one-cycle instruction memory write
//   busy, done, error     session status levels
//   cpu_hold              processor reset request, low only in DONE
module inst_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    FLUSH,
    DONE,
    ERROR
  } state_t;

  // Status flags: {byte_ready, busy, done, error, cpu_hold}
  localparam logic [4:0] F_IDLE  = 5'b00001;
  localparam logic [4:0] F_LOAD  = 5'b11001;
  localparam logic [4:0] F_FLUSH = 5'b01001;
  localparam logic [4:0] F_DONE  = 5'b00100;
  localparam logic [4:0] F_ERROR = 5'b00011;

  state_t                state;
  logic [7:0]            len_hi;
  logic [15:0]           len;
  logic [ADDR_WIDTH:0]   widx;
  logic [1:0]            bidx;
  logic [23:0]           shift;

  logic        accept;
  logic [15:0] n_word;
  logic        last_word;
  logic        too_long;

  assign accept    = byte_valid & byte_ready;
  assign n_word    = {len_hi, byte_data};
  // len is nonzero whenever DATA is reached, so len-1 never wraps
  assign last_word = (32'(widx) == (32'(len) - 32'd1));
  assign too_long  = (32'(n_word) > (32'd1 << ADDR_WIDTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      {byte_ready, busy, done, error, cpu_hold} <= F_IDLE;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      len_hi   <= '0;
      len      <= '0;
      widx     <= '0;
      bidx     <= '0;
      shift    <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state <= LEN_HI;
            {byte_ready, busy, done, error, cpu_hold} <= F_LOAD;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_hi <= byte_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len  <= n_word;
            widx <= '0;
            bidx <= '0;
            if (n_word == 16'd0) begin
              state <= DONE;
              {byte_ready, busy, done, error, cpu_hold} <= F_DONE;
            end else if (too_long) begin
              state <= ERROR;
              {byte_ready, busy, done, error, cpu_hold} <= F_ERROR;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shift <= {shift[15:0], byte_data};
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              // First byte lands in [31:24]; the ROM un-flips it
              mem_we   <= 1'b1;
              mem_addr <= 32'({widx[ADDR_WIDTH-1:0], 2'b00});
              mem_data <= {shift, byte_data};
              if (last_word) begin
                state <= FLUSH;
                {byte_ready, busy, done, error, cpu_hold} <= F_FLUSH;
              end else begin
                widx <= widx + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          state <= DONE;
          {byte_ready, busy, done, error, cpu_hold} <= F_DONE;
        end
        default: begin
          state <= IDLE;
          {byte_ready, busy, done, error, cpu_hold} <= F_IDLE;
        end
      endcase
    end
  end

endmodule
